// File: rtl/masked_subbytes_seq.sv
// rtl/masked_subbytes_seq.sv - sequential two-share SubBytes engine around a pipelined masked S-box core
//
// masked_sbox_core
//   Pipelined two-share S-box. A shared byte presented on din_i appears on
//   dout_o SBOX_LAT rising edges later, re-shared with a mask derived from
//   rnd_i.
//   clk, rst_n          clock, asynchronous active-low reset
//   din_i   [15:0]      {share0, share1} input byte
//   rnd_i   [RND_W-1:0] fresh randomness, one word per cycle
//   dout_o  [15:0]      {share0, share1} registered S-box output
//
// masked_subbytes_seq
//   Streams an N_BYTES two-share state through one core, one byte per cycle,
//   collects the shared results and pulses done when all bytes are captured.
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         operation request, sampled only in IDLE
//   state_in  [16*N_BYTES-1:0]    byte i = {share0, share1} at [16i+15:16i]
//   prng_in   [RND_W-1:0]         randomness forwarded to the core every cycle
//   rnd_valid                     randomness source valid; low while busy aborts
//   state_out [16*N_BYTES-1:0]    shared S-box results, same packing
//   busy, done, err               in progress, completion pulse, sticky abort

module masked_sbox_core #(
   parameter int SBOX_LAT = 4,
   parameter int RND_W    = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      din_i,
   input  logic [RND_W-1:0] rnd_i,
   output logic [15:0]      dout_o
);

   logic [15:0] pipe_q [SBOX_LAT];
   logic [7:0]  mask;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] t;
      r = 8'h01;
      t = x;
      for (int k = 1; k < 8; k++) begin
         t = gf_mul(t, t);
         r = gf_mul(r, t);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // Fold the whole randomness word into one fresh 8-bit output mask.
   always_comb begin
      mask = 8'h00;
      for (int b = 0; b < RND_W; b++) begin
         mask[b[2:0]] = mask[b[2:0]] ^ rnd_i[b];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SBOX_LAT; k++) pipe_q[k] <= 16'h0000;
      end else begin
         pipe_q[0] <= {sbox_fwd(din_i[15:8] ^ din_i[7:0]) ^ mask, mask};
         for (int k = 1; k < SBOX_LAT; k++) pipe_q[k] <= pipe_q[k-1];
      end
   end

   assign dout_o = pipe_q[SBOX_LAT-1];

endmodule

module masked_subbytes_seq #(
   parameter int N_BYTES  = 16,
   parameter int SBOX_LAT = 4,
   parameter int RND_W    = 22
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [16*N_BYTES-1:0]  state_in,
   input  logic [RND_W-1:0]       prng_in,
   input  logic                   rnd_valid,
   output logic [16*N_BYTES-1:0]  state_out,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int CW = $clog2(N_BYTES + 1);
   localparam logic [IW-1:0] F_LAST = IW'(N_BYTES - 1);
   localparam logic [CW-1:0] C_LAST = CW'(N_BYTES - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_e;

   state_e        st_q;
   logic [15:0]   buf_q [N_BYTES];
   logic [15:0]   out_q [N_BYTES];
   logic [SBOX_LAT-1:0] vsr_q;
   logic [IW-1:0] f_q;
   logic [CW-1:0] c_q;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic [15:0]   core_din;
   logic [15:0]   core_dout;

   // Only FEED presents real data; every other cycle feeds zero shares.
   always_comb begin
      core_din = 16'h0000;
      if (st_q == FEED) core_din = buf_q[f_q];
   end

   masked_sbox_core #(
      .SBOX_LAT (SBOX_LAT),
      .RND_W    (RND_W)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (core_din),
      .rnd_i  (prng_in),
      .dout_o (core_dout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= IDLE;
         vsr_q  <= '0;
         f_q    <= '0;
         c_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         for (int i = 0; i < N_BYTES; i++) begin
            buf_q[i] <= 16'h0000;
            out_q[i] <= 16'h0000;
         end
      end else begin
         done_q <= 1'b0;
         // The valid tail lines up with the core output of the byte fed
         // SBOX_LAT edges earlier.
         vsr_q[0] <= (st_q == FEED);
         for (int k = 1; k < SBOX_LAT; k++) vsr_q[k] <= vsr_q[k-1];

         case (st_q)
            IDLE: begin
               // busy_q stays high through the done cycle, which is spent in IDLE.
               busy_q <= 1'b0;
               if (start && rnd_valid) begin
                  st_q   <= FEED;
                  busy_q <= 1'b1;
                  err_q  <= 1'b0;
                  f_q    <= '0;
                  c_q    <= '0;
                  for (int i = 0; i < N_BYTES; i++) begin
                     buf_q[i] <= state_in[16*i +: 16];
                     out_q[i] <= 16'h0000;
                  end
               end
            end
            default: begin
               if (!rnd_valid) begin
                  // Abort: drop all shares, no done pulse.
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
                  err_q  <= 1'b1;
                  vsr_q  <= '0;
                  for (int i = 0; i < N_BYTES; i++) begin
                     buf_q[i] <= 16'h0000;
                     out_q[i] <= 16'h0000;
                  end
               end else begin
                  if (st_q == FEED) begin
                     buf_q[f_q] <= 16'h0000;
                     if (f_q == F_LAST) st_q <= DRAIN;
                     else               f_q  <= f_q + 1'b1;
                  end
                  if (vsr_q[SBOX_LAT-1]) begin
                     out_q[c_q[IW-1:0]] <= core_dout;
                     c_q <= c_q + 1'b1;
                     if (c_q == C_LAST) begin
                        st_q   <= IDLE;
                        done_q <= 1'b1;
                     end
                  end
               end
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_BYTES; gi++) begin : g_out
         assign state_out[16*gi +: 16] = out_q[gi];
      end
   endgenerate

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// tb/tb_masked_subbytes_seq.sv - self-checking bench for masked_subbytes_seq
module tb_masked_subbytes_seq;

   localparam int N  = 4;
   localparam int S  = 4;
   localparam int RW = 22;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [16*N-1:0] state_in = '0;
   logic [RW-1:0]   prng_in = '0;
   logic            rnd_valid = 1'b1;
   logic [16*N-1:0] state_out;
   logic            busy, done, err;

   int n_tests = 0;
   int n_fail  = 0;

   masked_subbytes_seq #(.N_BYTES(N), .SBOX_LAT(S), .RND_W(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .state_in  (state_in),
      .prng_in   (prng_in),
      .rnd_valid (rnd_valid),
      .state_out (state_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 prng_in = RW'($urandom);
   end

   task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference S-box: brute-force inverse search plus bitwise affine map.
   function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] o;
      inv = 8'h00;
      c   = 8'h63;
      for (int y = 1; y < 256; y++) if (gf_mul_ref(x, 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
         o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      return o;
   endfunction

   // Behavioural model: m_k counts edges since acceptance.
   logic       m_active, m_err, m_kept;
   int         m_k;
   logic [7:0] m_exp [N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_err    <= 1'b0;
         m_kept   <= 1'b0;
         m_k      <= 0;
      end else if ((!m_active || m_k == N + S) && start && rnd_valid) begin
         m_active <= 1'b1;
         m_kept   <= 1'b0;
         m_err    <= 1'b0;
         m_k      <= 0;
         for (int i = 0; i < N; i++)
            m_exp[i] <= sbox_ref(state_in[16*i+15 -: 8] ^ state_in[16*i+7 -: 8]);
      end else if (m_active && m_k < N + S && !rnd_valid) begin
         m_active <= 1'b0;
         m_err    <= 1'b1;
         m_kept   <= 1'b0;
      end else if (m_active && m_k == N + S) begin
         m_active <= 1'b0;
         m_kept   <= 1'b1;
      end else if (m_active) begin
         m_k <= m_k + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", busy === m_active, 64'(busy), 64'(m_active));
         chk("done", done === (m_active && m_k == N + S), 64'(done), 64'(m_active && m_k == N + S));
         chk("err", err === m_err, 64'(err), 64'(m_err));
         for (int i = 0; i < N; i++) begin
            if (m_kept || (m_active && m_k >= 1 + i + S))
               chk($sformatf("slot%0d_value", i),
                   (state_out[16*i+15 -: 8] ^ state_out[16*i+7 -: 8]) === m_exp[i],
                   64'(state_out[16*i+15 -: 8] ^ state_out[16*i+7 -: 8]), 64'(m_exp[i]));
            else
               chk($sformatf("slot%0d_zero", i), state_out[16*i +: 16] === 16'h0000,
                   64'(state_out[16*i +: 16]), 64'h0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [16*N-1:0] d);
      state_in  = d;
      start     = 1'b1;
      rnd_valid = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!done && lat < 30);
   endtask

   task automatic chk_res(input string name, input logic [31:0] exp);
      for (int i = 0; i < N; i++)
         chk(name, (state_out[16*i+15 -: 8] ^ state_out[16*i+7 -: 8]) == exp[8*i +: 8],
             64'(state_out[16*i+15 -: 8] ^ state_out[16*i+7 -: 8]), 64'(exp[8*i +: 8]));
   endtask

   localparam logic [63:0] DATA_A = {16'hA659, 16'h7677, 16'h3360, 16'hAAAA};
   localparam logic [63:0] DATA_B = {16'h99D9, 16'h0F3F, 16'hC3E3, 16'h5A4A};
   localparam logic [31:0] RES_A  = {8'h16, 8'h7C, 8'hED, 8'h63};
   localparam logic [31:0] RES_B  = {8'h09, 8'h04, 8'hB7, 8'hCA};

   initial begin
      int lat;
      int n;
      logic [31:0] sh1_run1;
      logic [31:0] sh1_run2;

      chk("model_sbox_00", sbox_ref(8'h00) == 8'h63, 64'(sbox_ref(8'h00)), 64'h63);
      chk("model_sbox_53", sbox_ref(8'h53) == 8'hED, 64'(sbox_ref(8'h53)), 64'hED);
      chk("model_sbox_01", sbox_ref(8'h01) == 8'h7C, 64'(sbox_ref(8'h01)), 64'h7C);
      chk("model_sbox_ff", sbox_ref(8'hFF) == 8'h16, 64'(sbox_ref(8'hFF)), 64'h16);

      // Reset with noise on the inputs.
      for (int i = 0; i < 4; i++) begin
         start     = 1'($urandom);
         rnd_valid = 1'($urandom);
         state_in  = {$urandom, $urandom};
         tick();
         chk("reset_outputs", {busy, done, err} == 3'b000 && state_out == '0,
             {61'(state_out[60:0]), busy, done, err}, 64'h0);
      end
      start = 1'b0; rnd_valid = 1'b1; rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_after_reset", busy == 1'b0, 64'(busy), 64'h0);

      // Basic operation then back-to-back.
      do_start(DATA_A);
      wait_done(lat);
      chk("done_latency", lat == N + S, 64'(lat), 64'(N + S));
      chk_res("result_a", RES_A);
      for (int i = 0; i < N; i++) sh1_run1[8*i +: 8] = state_out[16*i+7 -: 8];
      state_in = DATA_B;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat);
      chk("b2b_period", lat + 1 == N + S + 1, 64'(lat + 1), 64'(N + S + 1));
      chk_res("result_b", RES_B);
      repeat (3) tick();

      // Same data, fresh randomness: shares must change.
      do_start(DATA_A);
      wait_done(lat);
      chk("rerun_latency", lat == N + S, 64'(lat), 64'(N + S));
      for (int i = 0; i < N; i++) sh1_run2[8*i +: 8] = state_out[16*i+7 -: 8];
      chk("shares_differ", sh1_run1 != sh1_run2, 64'(sh1_run2), 64'(sh1_run1));
      repeat (2) tick();

      // Abort while byte 2 is being presented.
      do_start(DATA_A);
      tick();
      tick();
      rnd_valid = 1'b0;
      tick();
      rnd_valid = 1'b1;
      chk("abort_state", {busy, err} == 2'b01 && state_out == '0,
          {62'(state_out[61:0]), busy, err}, 64'h1);
      repeat (12) tick();
      do_start(DATA_B);
      wait_done(lat);
      chk("after_abort_latency", lat == N + S, 64'(lat), 64'(N + S));
      chk("after_abort_err", err == 1'b0, 64'(err), 64'h0);
      chk_res("after_abort_result", RES_B);
      repeat (2) tick();

      // start while busy is ignored.
      do_start(DATA_A);
      n = 0;
      while (!done && n < 30) begin
         if (n == 1) begin start = 1'b1; state_in = DATA_B; end
         if (n == 6) start = 1'b0;
         tick();
         n++;
      end
      start = 1'b0;
      chk("busy_start_latency", n == N + S, 64'(n), 64'(N + S));
      chk_res("busy_start_result", RES_A);
      repeat (2) tick();

      // start without valid randomness is ignored.
      start = 1'b1; rnd_valid = 1'b0;
      tick();
      start = 1'b0; rnd_valid = 1'b1;
      repeat (4) tick();
      chk("no_rnd_start", busy == 1'b0, 64'(busy), 64'h0);

      // Asynchronous reset during DRAIN.
      do_start(DATA_A);
      repeat (6) tick();
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset", {busy, done, err} == 3'b000 && state_out == '0,
          {61'(state_out[60:0]), busy, done, err}, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) tick();
      chk("post_reset_idle", busy == 1'b0, 64'(busy), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
